// File: rtl/img_stream_loader.sv
// rtl/img_stream_loader.sv - unpacks a UART byte stream into CNN input RAM pixels and starts the core
// Optional frame timeout enabled by defining LOADER_TIMEOUT_EN.
module img_stream_loader #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int PIX_BITS    = 1,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_rdy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PIX_BITS-1:0] wr_data,
    output logic                start,
    input  logic                done,
    output logic                busy,
    output logic [7:0]          drop_cnt,
    output logic                timeout
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int PPB  = 8 / PIX_BITS;
    localparam int CW   = ADDR_W + 1;
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
    localparam logic [CW-1:0] PPB_C  = CW'(PPB);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    sh_q, sh_d, hold_q, hold_d, drop_q, drop_d;
    logic          hold_vld_q, hold_vld_d;
    logic [3:0]    pcnt_q, pcnt_d;
    logic [CW-1:0] ptr_q, ptr_d, alloc_q, alloc_d;
    logic [CW-1:0] ptr_adv;
    logic [3:0]    n_new, n_alloc;
    logic          eng_free, load_hold, frame_full, drop_evt, tmo_fire;

    // Pixels the next byte contributes; tail pixels beyond NPIX are never counted.
    function automatic logic [3:0] take_cnt(input logic [CW-1:0] base);
        logic [CW-1:0] rem;
        rem = NPIX_C - base;
        if (rem >= PPB_C) take_cnt = 4'(PPB);
        else              take_cnt = 4'(rem);
    endfunction

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pcnt_d     = pcnt_q;
        ptr_d      = ptr_q;
        alloc_d    = alloc_q;
        drop_d     = drop_q;
        drop_evt   = 1'b0;
        ptr_adv    = ptr_q + CW'(pcnt_q != 4'd0);
        // Engine counts as free while writing its last pixel so refills leave no gap.
        eng_free   = pcnt_q <= 4'd1;
        load_hold  = eng_free && hold_vld_q;
        frame_full = alloc_q >= NPIX_C;
        n_new      = take_cnt(ptr_adv);
        n_alloc    = take_cnt(alloc_q);

        if (pcnt_q != 4'd0) begin
            pcnt_d = pcnt_q - 4'd1;
            ptr_d  = ptr_adv;
            sh_d   = sh_q >> PIX_BITS;
        end
        if (load_hold) begin
            sh_d       = hold_q;
            pcnt_d     = n_new;
            ptr_d      = ptr_adv;
            hold_vld_d = 1'b0;
        end

        if (rx_rdy) begin
            if ((state_q == S_IDLE || state_q == S_LOAD) && !frame_full && !tmo_fire) begin
                if (eng_free && !hold_vld_q) begin
                    sh_d    = rx_data;
                    pcnt_d  = n_new;
                    ptr_d   = ptr_adv;
                    alloc_d = alloc_q + CW'(n_alloc);
                    if (state_q == S_IDLE) state_d = S_LOAD;
                end else if (!hold_vld_q || load_hold) begin
                    hold_d     = rx_data;
                    hold_vld_d = 1'b1;
                    alloc_d    = alloc_q + CW'(n_alloc);
                end else begin
                    drop_evt = 1'b1;
                end
            end else begin
                drop_evt = 1'b1;
            end
        end

        case (state_q)
            S_LOAD: begin
                if (tmo_fire) begin
                    state_d    = S_IDLE;
                    ptr_d      = '0;
                    alloc_d    = '0;
                    pcnt_d     = 4'd0;
                    hold_vld_d = 1'b0;
                end else if (pcnt_q == 4'd1 && ptr_q == NPIX_C - CW'(1)) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (done) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    alloc_d = '0;
                end
            end
            default: ;
        endcase

        if (drop_evt && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            pcnt_q     <= '0;
            ptr_q      <= '0;
            alloc_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pcnt_q     <= pcnt_d;
            ptr_q      <= ptr_d;
            alloc_q    <= alloc_d;
            drop_q     <= drop_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT_CYC);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counter saturates so a busy engine merely postpones the abandon decision.
    always_comb begin
        tmo_fire  = (state_q == S_LOAD) && (tmo_cnt_q == TMO_C) && (pcnt_q == 4'd0) && !rx_rdy;
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != S_LOAD || rx_rdy || tmo_fire) tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_C)                 tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    assign wr_en    = pcnt_q != 4'd0;
    assign wr_addr  = ptr_q[ADDR_W-1:0];
    assign wr_data  = sh_q[PIX_BITS-1:0];
    assign start    = state_q == S_START;
    assign busy     = (state_q == S_START) || (state_q == S_RUN);
    assign drop_cnt = drop_q;
    assign timeout  = tmo_fire;
endmodule

// File: doc/img_stream_loader.md
# img_stream_loader

Parametrised image loader between the UART receiver and the CNN core. It accepts a byte stream on `rx_data`/`rx_rdy`, unpacks each byte into pixels of `PIX_BITS` bits, LSB first, and writes them one per cycle into the core's input RAM. When the frame is complete it issues a single `start` pulse, then holds off new frames until the core reports `done`. This is the successor to the fixed 1-bit, 28×28 loader: pixel width, image size, skid buffering, drop accounting and an optional frame timeout are added.

## Interface
- `IMG_W`, 28, image width in pixels
- `IMG_H`, 28, image height in pixels
- `PIX_BITS`, 1, bits per pixel; legal values 1, 2, 4, 8
- `ADDR_W`, 10, input RAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `TIMEOUT_CYC`, 50000, idle cycles inside a frame before it is abandoned (only with `LOADER_TIMEOUT_EN`)
- Derived values:
  - NPIX = IMG_W*IMG_H
  - PPB = 8/PIX_BITS
  - NBYTES = ceil(NPIX/PPB), which is 98 at defaults
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rx_data`  in  8  received byte; valid only while `rx_rdy`=1
- `rx_rdy`  in  1  one-cycle strobe per received byte
- `wr_en`  out  1  input RAM write enable
- `wr_addr`  out  ADDR_W  input RAM pixel address
- `wr_data`  out  PIX_BITS  pixel value
- `start`  out  1  one-cycle pulse when the frame is fully written
- `done`  in  1  one-cycle pulse from the core when inference has finished
- `busy`  out  1  high from `start` until `done` is accepted
- `drop_cnt`  out  8  count of dropped bytes; saturates at 255
- `timeout`  out  1  one-cycle pulse when a frame is abandoned

## Operation
- Reset values: all outputs 0; state IDLE; pixel pointer 0; hold register empty.
- States:
  - IDLE: the first accepted byte moves the FSM to LOAD.
  - LOAD: the last pixel write of the frame moves the FSM to START.
  - START: lasts one cycle with `start`=1, then moves to RUN.
  - RUN: `busy`=1; on `done`, moves to IDLE.
- Unpack engine:
  - Holds a shift register and a pixel counter. Byte b, pixel k maps to `wr_data` = `rx_data`[k*PIX_BITS +: PIX_BITS] at `wr_addr` = b*PPB + k.
  - One write per cycle.
  - Pixels with address ≥ NPIX in the last byte are discarded: no `wr_en`, no cycles spent on them.
- Byte acceptance while in IDLE or LOAD, decided per `rx_rdy`:
  - Engine idle: the byte loads straight into the engine.
  - Engine busy and hold register empty: the byte goes to the hold register. The engine takes it on the cycle after its last pixel, with no gap in writes.
  - Engine busy and hold register full: the byte is dropped and `drop_cnt` increments.
- `rx_rdy` in START or RUN: the byte is dropped and `drop_cnt` increments.
- If `done` and `rx_rdy` occur in the same RUN cycle, the byte is dropped and the FSM still returns to IDLE.
- Returning to IDLE clears the pixel pointer. RAM contents are never cleared.
- `drop_cnt` is cleared only by `rst`.
- `done` outside RUN is ignored.
- `rst` mid-frame: `wr_en` is 0 in the cycle after the reset edge, the partial frame is abandoned, and `start` is not issued.

## Timing
- `rx_rdy` at cycle t with the engine idle: pixel k is written at cycle t+1+k.
- A byte produces min(PPB, remaining pixels) write cycles.
- `start` is asserted in the cycle after the final write. At defaults, with the last byte at cycle t, `start` is at t+9.
- `busy` rises together with `start` and falls in the cycle after `done` is sampled.
- Sustained byte spacing ≥ PPB cycles is lossless. Up to one extra byte can be absorbed by the hold register.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - In LOAD, a counter runs while no `rx_rdy` is seen and is cleared by every `rx_rdy`.
  - When the counter reaches TIMEOUT_CYC: `timeout` pulses for one cycle, the pointer, engine and hold register clear, and the FSM returns to IDLE.
  - A pixel write in progress in that cycle completes first. The timeout is evaluated only while the engine is idle.
- Not defined: no counter exists, `timeout` is tied to 0, and a partial frame waits indefinitely.

## Test plan
- **Defaults, full frame:** 98 bytes spaced 11 cycles, byte0 = 8'hA5.
  - Addresses 0..7 receive 1,0,1,0,0,1,0,1.
  - The last write is to address 783.
  - `start` is a single pulse 9 cycles after the 98th `rx_rdy`.
  - `drop_cnt` = 0.
- **Discarded tail pixels:** IMG_W=IMG_H=3, PIX_BITS=4, 5 bytes, the last byte 8'hF2.
  - Exactly 9 writes occur; address 8 receives 4'h2.
  - There is no write to address 9.
  - `start` follows the write to address 8 by one cycle.
- **Back-to-back bytes (defaults):** `rx_rdy` on 3 consecutive cycles, bytes 8'hFF, 8'h00, 8'h55.
  - Addresses 0..15 are written in 16 consecutive cycles, 8×1 followed by 8×0.
  - The third byte is not written; `drop_cnt` = 1.
- **RUN phase:** after `start`, 2 bytes are sent, then `done`.
  - `drop_cnt` increments by 2.
  - `busy` falls 1 cycle after `done`.
  - The next byte is written at address 0.
- **Timeout (`LOADER_TIMEOUT_EN`, TIMEOUT_CYC=100):** 10 bytes, then silence.
  - `timeout` pulses once, about 100 cycles after the last write.
  - The next byte is written at address 0.
  - No `start` pulse has occurred.
- **Reset mid-frame:** `rst` asserted for 1 cycle while a byte is being unpacked.
  - `wr_en` = 0 in the next cycle; all outputs are 0.
  - The following frame loads from address 0 and completes normally.
